// File: rtl/btn_in_ctrl.sv
// Push-button input conditioner: per-bit synchronizer, debounce counter,
// stable level register and one-cycle press/release pulses.
module btn_in_ctrl #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_btns,
  output logic [WIDTH-1:0] btns,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic             any_pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0] sync_lvl;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] btns_d;
  logic [WIDTH-1:0] pressed_d;
  logic [WIDTH-1:0] released_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
    end else begin
      sync_chain[0] <= raw_btns;
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
    end
  end

  assign sync_lvl = sync_chain[SYNC_STAGES-1];

  // A level is accepted only after it has differed from btns on
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    btns_d     = btns;
    pressed_d  = '0;
    released_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_lvl[i] != btns[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          btns_d[i]     = sync_lvl[i];
          pressed_d[i]  = sync_lvl[i];
          released_d[i] = ~sync_lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      btns        <= '0;
      pressed     <= '0;
      released    <= '0;
      any_pressed <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      btns        <= btns_d;
      pressed     <= pressed_d;
      released    <= released_d;
      any_pressed <= |pressed_d;
    end
  end

endmodule

// File: tb/tb_btn_in_ctrl.sv
// Bench for btn_in_ctrl: default instance plus a SYNC_STAGES=3 / DEBOUNCE_CYCLES=1
// instance, checked every cycle against a window-based model and directed literals.
module tb_btn_in_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw_btns = 8'h00;

  logic [7:0] btnsA, pressedA, releasedA;
  logic       anyA;
  logic [7:0] btnsB, pressedB, releasedB;
  logic       anyB;

  int nAsserts = 0;
  int nFails   = 0;

  btn_in_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dutA (
    .clk(clk), .rst(rst), .raw_btns(raw_btns),
    .btns(btnsA), .pressed(pressedA), .released(releasedA), .any_pressed(anyA)
  );

  btn_in_ctrl #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dutB (
    .clk(clk), .rst(rst), .raw_btns(raw_btns),
    .btns(btnsB), .pressed(pressedB), .released(releasedB), .any_pressed(anyB)
  );

  always #5 clk = ~clk;

  // hist[k] is the raw level sampled k edges ago; a bit flips when the
  // level seen through the synchronizer differed from it for a full window.
  logic [7:0] hist [16];
  logic [7:0] mBtnsA = '0, mPressA = '0, mRelA = '0;
  logic [7:0] mBtnsB = '0, mPressB = '0, mRelB = '0;
  logic       mAnyA = 1'b0, mAnyB = 1'b0;
  logic [7:0] chg;

  function automatic logic [7:0] acceptMask(input int ss, input int dc, input logic [7:0] stable);
    logic [7:0] mask;
    mask = 8'hFF;
    for (int j = 0; j < dc; j++) mask = mask & (hist[j+ss] ^ stable);
    return mask;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) hist[k] = '0;
      mBtnsA = '0; mPressA = '0; mRelA = '0; mAnyA = 1'b0;
      mBtnsB = '0; mPressB = '0; mRelB = '0; mAnyB = 1'b0;
    end else begin
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = raw_btns;
      chg     = acceptMask(2, 4, mBtnsA);
      mPressA = chg & ~mBtnsA;
      mRelA   = chg & mBtnsA;
      mBtnsA  = mBtnsA ^ chg;
      mAnyA   = |mPressA;
      chg     = acceptMask(3, 1, mBtnsB);
      mPressB = chg & ~mBtnsB;
      mRelB   = chg & mBtnsB;
      mBtnsB  = mBtnsB ^ chg;
      mAnyB   = |mPressB;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  logic countOn = 1'b0;
  int   pressCntB = 0;
  int   relCntB = 0;
  logic [7:0] relSeen = '0;

  always @(negedge clk) begin
    checkOutput("btnsA", btnsA, mBtnsA);
    checkOutput("pressedA", pressedA, mPressA);
    checkOutput("releasedA", releasedA, mRelA);
    checkOutput("anyA", {7'b0, anyA}, {7'b0, mAnyA});
    checkOutput("btnsB", btnsB, mBtnsB);
    checkOutput("pressedB", pressedB, mPressB);
    checkOutput("releasedB", releasedB, mRelB);
    checkOutput("anyB", {7'b0, anyB}, {7'b0, mAnyB});
    checkOutput("pulseExclA", pressedA & releasedA, 8'h00);
    relSeen = relSeen | releasedA | releasedB;
    if (countOn) begin
      pressCntB += int'(pressedB[0]);
      relCntB   += int'(releasedB[0]);
    end
  end

  task automatic applyStimulus(input logic [7:0] v, input int n);
    raw_btns = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rstBtnsA", btnsA, 8'h00);
    checkOutput("rstPressA", pressedA, 8'h00);
    checkOutput("rstAnyA", {7'b0, anyA}, 8'h00);
    rst = 1'b0;

    // clean press and release of bit 0
    applyStimulus(8'h01, 5);
    checkOutput("pressE5", pressedA, 8'h00);
    checkOutput("btnsE5", btnsA, 8'h00);
    applyStimulus(8'h01, 1);
    checkOutput("pressE6", pressedA, 8'h01);
    checkOutput("btnsE6", btnsA, 8'h01);
    checkOutput("anyE6", {7'b0, anyA}, 8'h01);
    applyStimulus(8'h01, 1);
    checkOutput("pressE7", pressedA, 8'h00);
    applyStimulus(8'h00, 5);
    checkOutput("relE5", releasedA, 8'h00);
    applyStimulus(8'h00, 1);
    checkOutput("relE6", releasedA, 8'h01);
    checkOutput("relBtnsE6", btnsA, 8'h00);
    applyStimulus(8'h00, 1);
    checkOutput("relE7", releasedA, 8'h00);
    applyStimulus(8'h00, 4);

    // bounce rejection on bit 3
    applyStimulus(8'h08, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h08, 1);
    applyStimulus(8'h00, 8);
    checkOutput("bounceBtns", btnsA, 8'h00);
    applyStimulus(8'h08, 3);
    applyStimulus(8'h00, 8);
    checkOutput("short3Btns", btnsA, 8'h00);
    applyStimulus(8'h08, 6);
    checkOutput("longPress", pressedA, 8'h08);
    applyStimulus(8'h08, 2);
    applyStimulus(8'h00, 8);

    // simultaneous multi-bit transitions
    applyStimulus(8'hA5, 6);
    checkOutput("multiPress", pressedA, 8'hA5);
    checkOutput("multiBtns", btnsA, 8'hA5);
    checkOutput("multiAny", {7'b0, anyA}, 8'h01);
    applyStimulus(8'hA5, 2);
    applyStimulus(8'h5A, 6);
    checkOutput("swapPress", pressedA, 8'h5A);
    checkOutput("swapRel", releasedA, 8'hA5);
    applyStimulus(8'h5A, 2);
    applyStimulus(8'h00, 8);

    // reset in the middle of counting
    relSeen = '0;
    applyStimulus(8'hFF, 4);
    checkOutput("preRstBtnsB", btnsB, 8'hFF);
    rst = 1'b1;
    #1;
    checkOutput("asyncBtnsB", btnsB, 8'h00);
    checkOutput("asyncPressB", pressedB, 8'h00);
    checkOutput("asyncBtnsA", btnsA, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    applyStimulus(8'hFF, 5);
    checkOutput("postRstE5", pressedA, 8'h00);
    applyStimulus(8'hFF, 1);
    checkOutput("postRstE6", pressedA, 8'hFF);
    applyStimulus(8'hFF, 2);
    checkOutput("noRelOnRst", relSeen, 8'h00);
    applyStimulus(8'h00, 8);

    // DEBOUNCE_CYCLES=1 corner: bit 0 toggles every two cycles
    countOn = 1'b1;
    for (int t = 0; t < 8; t++) applyStimulus((t % 2 == 0) ? 8'h01 : 8'h00, 2);
    applyStimulus(8'h00, 6);
    countOn = 1'b0;
    nAsserts++;
    if (pressCntB != 4) begin
      nFails++;
      $display("[TB] FAIL togglePressCnt: got %0d expected 4", pressCntB);
    end
    nAsserts++;
    if (relCntB != 4) begin
      nFails++;
      $display("[TB] FAIL toggleRelCnt: got %0d expected 4", relCntB);
    end
    checkOutput("toggleBtnsA", btnsA, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/btn_in_ctrl.md
Name: btn_in_ctrl

Overview:
- Input-side counterpart to the LED output path in blinky_soc: conditions WIDTH raw push-button/switch pins for the SoC.
- Per-bit pipeline: metastability synchronizer, then debounce counter, then stable level, then one-cycle press/release pulses.
- Outputs feed the counter/control logic, for example a press pulse steps or resets the LED count.

Parameters:
- WIDTH, 8: number of independent button inputs.
- SYNC_STAGES, 2: synchronizer flop depth; legal range ≥2.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized level must differ from the stable level before it is accepted; legal range ≥1. Counter width is $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- raw_btns  input  WIDTH  asynchronous pin levels, 1 = pressed.
- btns  output  WIDTH  debounced stable level per bit.
- pressed  output  WIDTH  one-cycle pulse per bit on a stable 0→1 transition.
- released  output  WIDTH  one-cycle pulse per bit on a stable 1→0 transition.
- any_pressed  output  1  OR-reduction of pressed, registered in the same cycle as pressed.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. Asserting rst immediately clears all state. Release is synchronous to clk in the system.
- Reset values: all synchronizer flops, debounce counters, btns, pressed, released and any_pressed are 0.
- Synchronizer: a SYNC_STAGES-deep flop chain per bit. sync[i] is the last stage. No combinational path from raw_btns to any output.
- Debounce, per bit, evaluated every clk edge:
  - sync[i] == btns[i]: counter cleared to 0; no pulse.
  - sync[i] != btns[i] and counter < DEBOUNCE_CYCLES-1: counter increments; no pulse.
  - sync[i] != btns[i] and counter == DEBOUNCE_CYCLES-1: btns[i] <= sync[i]; counter cleared; pressed[i] <= sync[i]; released[i] <= ~sync[i].
- Pulses: pressed/released deassert on the following edge unless a new transition occurs. For a given bit they are never both 1. A new transition cannot occur within DEBOUNCE_CYCLES edges, so pulses are always isolated single cycles.
- Latency: raw level first captured on edge 1. btns, and the pulse, update on edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults).
- Glitch rejection: any return of sync[i] to btns[i] before the count completes clears the counter. A bounce shorter than DEBOUNCE_CYCLES cycles never changes btns.
- DEBOUNCE_CYCLES=1: btns follows sync with one edge of delay, and pulses on every change.
- Independence: bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses. any_pressed is 1 when at least one pressed bit is 1.
- Reset mid-operation: counters and pulses are discarded; btns returns to 0.
  - If raw_btns stays high through and after reset, a fresh pressed pulse occurs SYNC_STAGES+DEBOUNCE_CYCLES edges after rst deasserts.
  - No released pulse is generated by reset itself.
- Counter saturation cannot occur: the counter never exceeds DEBOUNCE_CYCLES-1.

Test Plan:
- Clean press, defaults: raw_btns 0x00→0x01 held.
  - btns=0x01 and pressed=0x01, any_pressed=1 on edge 6 only.
  - pressed=0x00 on edge 7.
  - Release to 0x00 → released=0x01 single pulse on edge 6 after the change.
- Bounce rejection: raw bit 3 toggles 1,0,1,0 at one-cycle intervals, then stays 0.
  - btns, pressed and released remain 0x00 throughout.
  - Then hold 1 for 3 cycles and drop: still no change.
  - Hold ≥4 cycles: pressed=0x08 once.
- Simultaneous multi-bit: raw_btns 0x00→0xA5 in one cycle.
  - pressed=0xA5 and any_pressed=1 in one cycle; btns=0xA5.
  - Then 0xA5→0x5A gives pressed=0x5A and released=0xA5 in the same cycle.
- Reset mid-count: raw_btns=0xFF, assert rst on edge 4 (before acceptance).
  - Outputs go to 0 immediately, asynchronously.
  - Deassert rst with raw still 0xFF: pressed=0xFF exactly 6 edges later; no released pulse at any point.
- Parameter corner, DEBOUNCE_CYCLES=1, SYNC_STAGES=3: toggle raw bit 0 every 2 cycles.
  - btns[0] mirrors raw delayed 4 edges.
  - pressed and released alternate as single-cycle pulses with no drops.
